// File: rtl/pia_dsp_sched.sv
// Buffers PIA display characters in a FIFO and replays them to the terminal over rdy/ack, tracking the cursor column.
// out_rdy rises the cycle after in_ack; a full FIFO withholds in_ack. Optional auto line wrap under `DSP_AUTOWRAP_EN.
module pia_dsp_sched #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int COLS  = 40
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_rdy,
   input  logic [6:0]    in_data,
   output logic          in_ack,
   output logic          out_rdy,
   output logic [6:0]    out_data,
   input  logic          out_ack,
   output logic [AW:0]   fifo_level,
   output logic [5:0]    col,
   output logic          busy
);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

   localparam logic [6:0]  CHAR_CR = 7'h0D;
   localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
   localparam logic [5:0]  COL_MAX = 6'(COLS);

   logic [6:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          armed;
   logic          ins_cr;
   state_t        state;
   logic          push;
   logic          pop;
   logic [6:0]    head;

   function automatic logic printable(input logic [6:0] c);
      return (c >= 7'h20) && (c <= 7'h7E);
   endfunction

   assign head = mem[rd_ptr];
   // Space is judged on the registered level only, so a same-cycle pop never makes room for a push.
   assign push = in_rdy && armed && (fifo_level < FULL);
   assign pop  = (state == S_SEND) && out_ack && !ins_cr;
   assign busy = (fifo_level != '0) | out_rdy;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         armed      <= 1'b1;
         in_ack     <= 1'b0;
         state      <= S_IDLE;
         out_rdy    <= 1'b0;
         out_data   <= '0;
         col        <= '0;
         ins_cr     <= 1'b0;
      end else begin
         in_ack <= push;

         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            armed  <= 1'b0;
         end else if (!in_rdy) begin
            armed  <= 1'b1;
         end

         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end

         if (push && !pop) begin
            fifo_level <= fifo_level + 1'b1;
         end else if (!push && pop) begin
            fifo_level <= fifo_level - 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (fifo_level != '0) begin
`ifdef DSP_AUTOWRAP_EN
                  // A printable head at the right margin is preceded by a CR; the head stays queued.
                  if ((col == COL_MAX) && printable(head)) begin
                     out_data <= CHAR_CR;
                     ins_cr   <= 1'b1;
                  end else begin
                     out_data <= head;
                     ins_cr   <= 1'b0;
                  end
`else
                  out_data <= head;
                  ins_cr   <= 1'b0;
`endif
                  out_rdy <= 1'b1;
                  state   <= S_SEND;
               end
            end
            S_SEND: begin
               if (out_ack) begin
                  out_rdy <= 1'b0;
                  state   <= S_GAP;
                  if (out_data == CHAR_CR) begin
                     col <= '0;
                  end else if (printable(out_data) && (col < COL_MAX)) begin
                     col <= col + 1'b1;
                  end
               end
            end
            S_GAP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
